utf8_decoder: RTL and testbench
===============================

Name: utf8_decoder

Overview:
- Streaming UTF-8 decoder that consumes the byte stream produced by an upstream byte source (8-bit text bytes) and emits Unicode scalar values one per handshake.
- Optionally strips a leading byte order mark (EF BB BF).
- Replaces every malformed sequence with U+FFFD, flags it, and counts it.
- Sits between a byte-oriented text source and any code-point consumer (font lookup, console).

Parameters:
STRIP_BOM, 1, when 1 a U+FEFF decoded as the first scalar after reset is dropped, not emitted
ERR_W, 16, width of saturating error counter

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high
in_data  input  8  incoming UTF-8 byte
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready at clock edge
out_cp  output  21  decoded scalar value
out_err  output  1  out_cp is a U+FFFD substitution for malformed input
out_valid  output  1  out_cp/out_err valid
out_ready  input  1  consumer accepts when out_valid && out_ready
bom_seen  output  1  sticky; leading BOM was detected (set even if STRIP_BOM=0)
err_count  output  ERR_W  saturating count of emitted substitutions

Behaviour:
- Reset (sync, active-high): state=START, out_valid=0, out_cp=0, out_err=0, bom_seen=0, err_count=0, first-scalar flag=1. Reset mid-sequence discards partial accumulation and drops any pending output.
- Output register: one entry. Slot free = !out_valid || out_ready. A new result loads only when the slot is free; otherwise the decoder stalls.
- in_ready = slot free && !replay, where replay = state==CONT && in_data is not a valid next byte. in_ready therefore depends combinationally on in_data; this is intentional.
- Latency: out_valid rises the cycle after the handshake of the final byte of a sequence (1 cycle). Throughput is 1 byte/cycle when out_ready=1.
- States:
  - START expects a lead byte.
  - CONT holds: remaining count (1..3), accumulator (21b), lo/hi bounds for the next byte.
- START, byte accepted:
  - 00-7F: emit the byte zero-extended as the scalar; stay in START.
  - C2-DF: acc=b[4:0], remaining=1.
  - E0-EF: acc=b[3:0], remaining=2.
  - F0-F4: acc=b[2:0], remaining=3. Go to CONT.
  - 80-BF, C0, C1, F5-FF: emit FFFD with err=1; byte consumed; stay in START.
- Second-byte bounds (all other continuation bytes use 80-BF):
  - E0: A0-BF.
  - ED: 80-9F (excludes surrogates).
  - F0: 90-BF.
  - F4: 80-8F.
- CONT, byte in bounds: acc=(acc<<6)|b[5:0], remaining--. When remaining reaches 0, emit acc and return to START.
- CONT, byte out of bounds: emit FFFD with err=1 and return to START. The byte is not consumed (in_ready=0) and is re-evaluated as a lead byte next cycle. One FFFD is emitted per maximal truncated subpart.
- Stall: in START, a lead byte with no slot free is not accepted. In CONT, a continuation byte is accepted while the slot is full only if it is not the final byte. Simplification: all acceptance is gated on slot free.
- BOM handling:
  - The first completed scalar after reset clears the first-scalar flag.
  - If that scalar is FEFF, set bom_seen.
  - If STRIP_BOM=1, do not load the output (out_valid unchanged).
  - FEFF appearing later is emitted normally.
- err_count increments on each FFFD load and saturates at all-ones.
- out_cp/out_err hold their value while out_valid && !out_ready.

Decomposition:
- Package utf8_pkg holds:
  - CP_REPLACEMENT=21'h00FFFD, CP_BOM=21'h00FEFF;
  - state enum {START, CONT};
  - struct lead_info_t {len[1:0], init_bits[6:0], lo[7:0], hi[7:0], invalid}.
- One combinational sub-module, utf8_lead_classify: maps a lead byte to lead_info_t. It is a natural unit to test exhaustively over 256 values.

Test Plan:
- Reset, then bytes EF BB BF 41 with STRIP_BOM=1, out_ready=1 -> single output 0x41 err=0; bom_seen=1; err_count=0.
- Bytes E2 82 AC F0 9F 98 80 -> outputs 0x20AC then 0x1F600, each one cycle after its last byte; no err.
- Malformed input C0 AF, ED A0 80, F5 -> five FFFD outputs, err=1 each (C0, AF, ED, A0, 80 treated per rules: ED then A0 out of bounds gives FFFD for ED, A0 and 80 stray), then one more FFFD for F5; err_count=6.
- Truncation: E2 82 41 -> FFFD err=1, then 0x41. in_ready=0 on the cycle 41 is first presented in CONT.
- Backpressure: out_ready=0 for 5 cycles after first output of 41 42 -> out_cp holds 0x41, in_ready=0, 0x42 is emitted after release; no loss or duplication.
- Reset asserted after E2 82 -> no output; then 41 -> 0x41. Also: FEFF as the second scalar is emitted normally; 70000 bad bytes leave err_count saturated at 0xFFFF.

Source files
------------

// File: rtl/utf8_pkg.sv
// rtl/utf8_pkg.sv - shared types and constants for the UTF-8 decoder
package utf8_pkg;

  localparam logic [20:0] CP_REPLACEMENT = 21'h00FFFD;
  localparam logic [20:0] CP_BOM         = 21'h00FEFF;

  typedef enum logic {
    START = 1'b0,
    CONT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] len;
    logic [6:0] init_bits;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       invalid;
  } lead_info_t;

endpackage

// File: rtl/utf8_lead_classify.sv
// rtl/utf8_lead_classify.sv - maps a lead byte to sequence length, payload bits and second-byte bounds
module utf8_lead_classify
  import utf8_pkg::*;
(
  input  logic [7:0] lead_byte,
  output lead_info_t info
);

  always_comb begin
    info.len       = 2'd0;
    info.init_bits = 7'd0;
    info.lo        = 8'h80;
    info.hi        = 8'hBF;
    info.invalid   = 1'b1;
    if (lead_byte < 8'h80) begin
      info.invalid   = 1'b0;
      info.init_bits = lead_byte[6:0];
    end else if (lead_byte >= 8'hC2 && lead_byte <= 8'hDF) begin
      info.invalid   = 1'b0;
      info.len       = 2'd1;
      info.init_bits = {2'b00, lead_byte[4:0]};
    end else if (lead_byte >= 8'hE0 && lead_byte <= 8'hEF) begin
      info.invalid   = 1'b0;
      info.len       = 2'd2;
      info.init_bits = {3'b000, lead_byte[3:0]};
      // E0 rejects overlongs, ED rejects surrogates
      if (lead_byte == 8'hE0) info.lo = 8'hA0;
      if (lead_byte == 8'hED) info.hi = 8'h9F;
    end else if (lead_byte >= 8'hF0 && lead_byte <= 8'hF4) begin
      info.invalid   = 1'b0;
      info.len       = 2'd3;
      info.init_bits = {4'b0000, lead_byte[2:0]};
      if (lead_byte == 8'hF0) info.lo = 8'h90;
      if (lead_byte == 8'hF4) info.hi = 8'h8F;
    end
  end

endmodule

// File: rtl/utf8_decoder.sv
// rtl/utf8_decoder.sv - streaming UTF-8 to scalar decoder with U+FFFD substitution and BOM strip
module utf8_decoder
  import utf8_pkg::*;
#(
  parameter int STRIP_BOM = 1,
  parameter int ERR_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [20:0]      out_cp,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             bom_seen,
  output logic [ERR_W-1:0] err_count
);

  state_t      state, state_n;
  logic [1:0]  rem, rem_n;
  logic [20:0] acc, acc_n;
  logic [7:0]  lo, lo_n, hi, hi_n;
  logic        first_scalar;
  lead_info_t  lead;

  logic        slot_free, in_bounds, replay;
  logic        emit, emit_err;
  logic [20:0] emit_cp;
  logic        is_bom, load;

  utf8_lead_classify u_classify (
    .lead_byte (in_data),
    .info      (lead)
  );

  assign slot_free = !out_valid || out_ready;
  assign in_bounds = (in_data >= lo) && (in_data <= hi);
  // An out-of-bounds continuation byte is not consumed; it is replayed as a lead byte.
  assign replay    = (state == CONT) && !in_bounds;
  assign in_ready  = slot_free && !replay;

  always_comb begin
    state_n  = state;
    rem_n    = rem;
    acc_n    = acc;
    lo_n     = lo;
    hi_n     = hi;
    emit     = 1'b0;
    emit_cp  = '0;
    emit_err = 1'b0;
    if (in_valid && slot_free) begin
      if (state == START) begin
        if (lead.invalid) begin
          emit     = 1'b1;
          emit_cp  = CP_REPLACEMENT;
          emit_err = 1'b1;
        end else if (lead.len == 2'd0) begin
          emit    = 1'b1;
          emit_cp = {14'd0, lead.init_bits};
        end else begin
          state_n = CONT;
          rem_n   = lead.len;
          acc_n   = {14'd0, lead.init_bits};
          lo_n    = lead.lo;
          hi_n    = lead.hi;
        end
      end else if (in_bounds) begin
        acc_n = (acc << 6) | {15'd0, in_data[5:0]};
        lo_n  = 8'h80;
        hi_n  = 8'hBF;
        if (rem == 2'd1) begin
          emit    = 1'b1;
          emit_cp = acc_n;
          state_n = START;
        end else begin
          rem_n = rem - 2'd1;
        end
      end else begin
        emit     = 1'b1;
        emit_cp  = CP_REPLACEMENT;
        emit_err = 1'b1;
        state_n  = START;
      end
    end
  end

  assign is_bom = emit && !emit_err && first_scalar && (emit_cp == CP_BOM);
  assign load   = emit && !((STRIP_BOM != 0) && is_bom);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= START;
      rem          <= 2'd0;
      acc          <= '0;
      lo           <= 8'h80;
      hi           <= 8'hBF;
      first_scalar <= 1'b1;
      out_valid    <= 1'b0;
      out_cp       <= '0;
      out_err      <= 1'b0;
      bom_seen     <= 1'b0;
      err_count    <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      acc   <= acc_n;
      lo    <= lo_n;
      hi    <= hi_n;
      if (emit) first_scalar <= 1'b0;
      if (is_bom) bom_seen <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_cp    <= emit_cp;
        out_err   <= emit_err;
        if (emit_err && !(&err_count))
          err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_utf8_decoder.sv
// tb/tb_utf8_decoder.sv - scoreboard bench for utf8_decoder
module tb_utf8_decoder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [20:0] out_cp;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        bom_seen;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;
  logic [21:0] exp_q[$];

  utf8_decoder #(.STRIP_BOM(1), .ERR_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_cp    (out_cp),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bom_seen  (bom_seen),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  // Monitor: inputs settle by negedge+1, so a handshake is judged at negedge+2.
  always begin
    @(negedge clock);
    #2;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got cp=%h err=%0b, none expected", out_cp, out_err);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({out_err, out_cp} !== e) begin
          fails++;
          $display("FAIL output: got cp=%h err=%0b, expected cp=%h err=%0b",
                   out_cp, out_err, e[20:0], e[21]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_cp(input logic [20:0] cp, input logic err);
    exp_q.push_back({err, cp});
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%0b", b, in_ready);
    end
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    #3;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_bom_seen", bom_seen, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);

    // Leading BOM stripped
    expect_cp(21'h41, 1'b0);
    send_byte(8'hEF); send_byte(8'hBB); send_byte(8'hBF); send_byte(8'h41);
    drain();
    check("bom_seen", bom_seen, 1);
    check("bom_err_count", err_count, 0);

    // Multibyte scalars, one-cycle latency
    expect_cp(21'h020AC, 1'b0);
    expect_cp(21'h1F600, 1'b0);
    send_byte(8'hE2); send_byte(8'h82); send_byte(8'hAC);
    check("lat_20ac_valid", out_valid, 1);
    check("lat_20ac_cp", out_cp, 21'h020AC);
    send_byte(8'hF0); send_byte(8'h9F); send_byte(8'h98); send_byte(8'h80);
    check("lat_1f600_valid", out_valid, 1);
    check("lat_1f600_cp", out_cp, 21'h1F600);
    drain();
    check("mb_err_count", err_count, 0);

    // Malformed: C0 AF ED A0 80 F5 -> six substitutions
    repeat (6) expect_cp(21'h00FFFD, 1'b1);
    send_byte(8'hC0); send_byte(8'hAF);
    send_byte(8'hED); send_byte(8'hA0); send_byte(8'h80);
    send_byte(8'hF5);
    drain();
    check("malformed_err_count", err_count, 6);

    // Truncation: E2 82 41
    expect_cp(21'h00FFFD, 1'b1);
    expect_cp(21'h41, 1'b0);
    send_byte(8'hE2); send_byte(8'h82);
    in_data  = 8'h41;
    in_valid = 1'b1;
    #1;
    check("trunc_in_ready_low", in_ready, 0);
    send_byte(8'h41);
    drain();
    check("trunc_err_count", err_count, 7);

    // Backpressure holds output and stalls input
    expect_cp(21'h41, 1'b0);
    expect_cp(21'h42, 1'b0);
    out_ready = 1'b0;
    send_byte(8'h41);
    in_data  = 8'h42;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", out_valid, 1);
      check("bp_cp_hold", out_cp, 21'h41);
      check("bp_in_ready", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    send_byte(8'h42);
    drain();

    // Reset mid-sequence drops partial data
    send_byte(8'hE2); send_byte(8'h82);
    do_reset();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_err_count", err_count, 0);
    expect_cp(21'h41, 1'b0);
    send_byte(8'h41);
    drain();

    // FEFF as second scalar is emitted normally
    expect_cp(21'h00FEFF, 1'b0);
    send_byte(8'hEF); send_byte(8'hBB); send_byte(8'hBF);
    drain();
    check("late_bom_not_seen", bom_seen, 0);

    // Error counter saturation
    for (int i = 0; i < 70000; i++) begin
      expect_cp(21'h00FFFD, 1'b1);
      send_byte(8'hFF);
    end
    drain();
    check("err_count_sat", err_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
